// File: rtl/ddr_arb_pkg.sv
// Shared constants and owner state encoding for the DDR command arbiter.
package ddr_arb_pkg;

    localparam int unsigned CREDITS   = 8;  // downstream command FIFO depth
    localparam int unsigned BURST_MAX = 4;  // consecutive grants to one port under contention
    localparam int unsigned CRD_W     = 4;  // holds 0..CREDITS
    localparam int unsigned BST_W     = 3;  // holds 0..BURST_MAX

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } own_e;

endpackage

// File: rtl/ddr_cmd_arb_2to1_if.sv
// Request/grant/credit bundle between the two source FIFOs, the mux and the arbiter.
interface ddr_cmd_arb_2to1_if;
    import ddr_arb_pkg::*;

    logic             req0_i;
    logic             req1_i;
    logic             credit_ret_i;
    logic [1:0]       sel_en_o;
    logic             gnt0_o;
    logic             gnt1_o;
    logic [CRD_W-1:0] credit_cnt_o;
    logic             owner_o;
    logic             err_o;

    // Arbiter side
    modport slave (
        input  req0_i, req1_i, credit_ret_i,
        output sel_en_o, gnt0_o, gnt1_o, credit_cnt_o, owner_o, err_o
    );

    // Requester / environment side
    modport master (
        output req0_i, req1_i, credit_ret_i,
        input  sel_en_o, gnt0_o, gnt1_o, credit_cnt_o, owner_o, err_o
    );

endinterface

// File: rtl/ddr_credit_counter.sv
// Saturating credit counter: down on consume, up on return, sticky error on
// a return that would exceed MAX. Simultaneous up/down leaves the count alone.
module ddr_credit_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         zero_c,
    output logic         full_c,
    output logic         ovf_err
);

    assign zero_c = (count == '0);
    assign full_c = (count == W'(MAX));

    // Count update and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= W'(MAX);
            ovf_err <= 1'b0;
        end else begin
            if (up && !down) begin
                if (full_c) begin
                    ovf_err <= 1'b1;
                end else begin
                    count <= count + W'(1);
                end
            end else if (down && !up && !zero_c) begin
                count <= count - W'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_arb_2to1.sv
// Round-robin 2:1 arbiter with burst limit and credit guard. Grants are
// combinational from req and registered state so the mux registers the word
// in the next cycle; credit returns only influence grants through the counter.
module ddr_cmd_arb_2to1
    import ddr_arb_pkg::*;
(
    input logic               clk,
    input logic               rst,
    ddr_cmd_arb_2to1_if.slave bus
);

    own_e             state_q;
    own_e             state_d;
    logic [BST_W-1:0] burst_q;
    logic [BST_W-1:0] burst_d;
    logic             gnt0;
    logic             gnt1;
    logic             crd_zero;
    logic             unused_crd_full;

    // Owner pointer and burst count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OWN0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Grant selection and owner/burst next state
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        if (!rst && !crd_zero) begin
            if (bus.req0_i && bus.req1_i) begin
                if (burst_q < BST_W'(BURST_MAX)) begin
                    gnt0 = (state_q == OWN0);
                    gnt1 = (state_q == OWN1);
                end else begin
                    gnt0 = (state_q == OWN1);
                    gnt1 = (state_q == OWN0);
                end
            end else begin
                gnt0 = bus.req0_i;
                gnt1 = bus.req1_i;
            end
        end

        if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1)) begin
            if (burst_q < BST_W'(BURST_MAX)) begin
                burst_d = burst_q + BST_W'(1);
            end
        end else if (gnt0 || gnt1) begin
            state_d = gnt1 ? OWN1 : OWN0;
            burst_d = BST_W'(1);
        end
    end

    assign bus.sel_en_o = {gnt1, gnt0};
    assign bus.gnt0_o   = gnt0;
    assign bus.gnt1_o   = gnt1;
    assign bus.owner_o  = (state_q == OWN1);

    // Downstream FIFO credits: consumed per grant, returned by the sink
    ddr_credit_counter #(
        .W   (CRD_W),
        .MAX (CREDITS)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .up      (bus.credit_ret_i),
        .down    (gnt0 | gnt1),
        .count   (bus.credit_cnt_o),
        .zero_c  (crd_zero),
        .full_c  (unused_crd_full),
        .ovf_err (bus.err_o)
    );

endmodule

// File: tb/tb_ddr_cmd_arb_2to1.sv
// Directed bench for ddr_cmd_arb_2to1: expected per-cycle outputs are queued
// as each step is driven and popped when the outputs are sampled mid-cycle.
module tb_ddr_cmd_arb_2to1;
    import ddr_arb_pkg::*;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic [3:0] cnt;
        logic       own;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    exp_t sb_q[$];

    // Burst fairness expectations for cycles 2..10 of continuous contention
    logic [1:0] burst_sel [9] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    logic       burst_own [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    ddr_cmd_arb_2to1_if bus();

    ddr_cmd_arb_2to1 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [1:0] sel, input logic [3:0] cnt,
                              input logic own, input logic err);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.cnt = cnt;
        e.own = own;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, "sel_en", 8'(bus.sel_en_o), 8'(e.sel));
            chk(e.tag, "gnt0", 8'(bus.gnt0_o), 8'(e.sel[0]));
            chk(e.tag, "gnt1", 8'(bus.gnt1_o), 8'(e.sel[1]));
            chk(e.tag, "credit_cnt", 8'(bus.credit_cnt_o), 8'(e.cnt));
            chk(e.tag, "owner", 8'(bus.owner_o), 8'(e.own));
            chk(e.tag, "err", 8'(bus.err_o), 8'(e.err));
        end
    endtask

    // One cycle: drive just after the rising edge, check mid-cycle
    task automatic cyc(input string tag, input logic r0, input logic r1, input logic ret,
                       input logic [1:0] sel, input logic [3:0] cnt, input logic own, input logic err);
        bus.req0_i       = r0;
        bus.req1_i       = r1;
        bus.credit_ret_i = ret;
        expect_now(tag, sel, cnt, own, err);
        #3;
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        cyc(tag, 1'b1, 1'b1, 1'b0, 2'b00, 4'd8, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        total            = 0;
        passed           = 0;
        rst              = 1'b1;
        bus.req0_i       = 1'b1;
        bus.req1_i       = 1'b1;
        bus.credit_ret_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset hold with both requests, then first grant to port0
        cyc("rst_hold", 1'b1, 1'b1, 1'b0, 2'b00, 4'd8, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("rst_rel", 1'b1, 1'b1, 1'b0, 2'b01, 4'd8, 1'b0, 1'b0);

        // Burst fairness with a credit return every cycle
        for (int i = 0; i < 9; i++) begin
            cyc("burst", 1'b1, 1'b1, 1'b1, burst_sel[i], 4'd7, burst_own[i], 1'b0);
        end

        // Credit exhaustion on port0 alone
        do_reset("rst_exh");
        for (int i = 0; i < 8; i++) begin
            cyc("exh", 1'b1, 1'b0, 1'b0, 2'b01, 4'(8 - i), 1'b0, 1'b0);
        end
        cyc("exh_empty0", 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        cyc("exh_empty1", 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        cyc("exh_ret", 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0);
        cyc("exh_k1", 1'b1, 1'b0, 1'b0, 2'b01, 4'd1, 1'b0, 1'b0);
        cyc("exh_k2", 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);

        // Grant and return in the same cycle at count 3
        cyc("sim_ret0", 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0);
        cyc("sim_ret1", 1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 1'b0, 1'b0);
        cyc("sim_ret2", 1'b0, 1'b0, 1'b1, 2'b00, 4'd2, 1'b0, 1'b0);
        cyc("sim_both", 1'b1, 1'b0, 1'b1, 2'b01, 4'd3, 1'b0, 1'b0);
        cyc("sim_hold", 1'b0, 1'b0, 1'b0, 2'b00, 4'd3, 1'b0, 1'b0);

        // Lone req1 during OWN0 with burst 2 flips owner and restarts burst at 1
        do_reset("rst_lone");
        cyc("lone_pre0", 1'b1, 1'b0, 1'b0, 2'b01, 4'd8, 1'b0, 1'b0);
        cyc("lone_pre1", 1'b1, 1'b0, 1'b0, 2'b01, 4'd7, 1'b0, 1'b0);
        cyc("lone1", 1'b0, 1'b1, 1'b0, 2'b10, 4'd6, 1'b0, 1'b0);
        cyc("lone_b2", 1'b1, 1'b1, 1'b0, 2'b10, 4'd5, 1'b1, 1'b0);
        cyc("lone_b3", 1'b1, 1'b1, 1'b0, 2'b10, 4'd4, 1'b1, 1'b0);
        cyc("lone_b4", 1'b1, 1'b1, 1'b0, 2'b10, 4'd3, 1'b1, 1'b0);
        cyc("lone_sw", 1'b1, 1'b1, 1'b0, 2'b01, 4'd2, 1'b1, 1'b0);
        cyc("lone_idle", 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 1'b0, 1'b0);

        // Overflow: return at full credit sets a sticky error
        do_reset("rst_ovf");
        cyc("ovf_ret", 1'b0, 1'b0, 1'b1, 2'b00, 4'd8, 1'b0, 1'b0);
        cyc("ovf_set", 1'b0, 1'b0, 1'b0, 2'b00, 4'd8, 1'b0, 1'b1);
        cyc("ovf_stick", 1'b1, 1'b0, 1'b0, 2'b01, 4'd8, 1'b0, 1'b1);
        cyc("ovf_stick2", 1'b0, 1'b0, 1'b0, 2'b00, 4'd7, 1'b0, 1'b1);
        do_reset("rst_ovf_clr");
        cyc("ovf_clr", 1'b0, 1'b0, 1'b0, 2'b00, 4'd8, 1'b0, 1'b0);

        // Reset asserted mid-cycle during a port1 burst
        cyc("mid_g0", 1'b0, 1'b1, 1'b0, 2'b10, 4'd8, 1'b0, 1'b0);
        cyc("mid_g1", 1'b0, 1'b1, 1'b0, 2'b10, 4'd7, 1'b1, 1'b0);
        bus.req1_i = 1'b1;
        expect_now("mid_pre", 2'b10, 4'd6, 1'b1, 1'b0);
        #2;
        compare_out();
        rst = 1'b1;
        expect_now("mid_async", 2'b00, 4'd8, 1'b0, 1'b0);
        #1;
        compare_out();
        @(posedge clk);
        #1;
        cyc("mid_hold", 1'b0, 1'b1, 1'b0, 2'b00, 4'd8, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("mid_rel", 1'b0, 1'b1, 1'b0, 2'b10, 4'd8, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
